rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Sequential round-robin arbiter that shares one resource among NUM_PORTS requesters.
- Replaces fixed-priority selection where fairness and grant hold (lock) are needed.
- The winner keeps the grant for as long as its request stays high. The pointer then rotates past the last owner.
- Sits between requester ports and a shared datapath resource (bus, memory port, or functional unit).

Parameters:
- NUM_PORTS, 4, number of requesters. Must be at least 2.
- MAX_BURST, 8, maximum consecutive granted cycles per owner when the burst limit is compiled in. Must be at least 1.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- requests_i  input  NUM_PORTS  request per port. A requester holds it high for the whole time it needs the resource.
- grants_o  output  NUM_PORTS  registered one-hot grant, or all zero.
- grant_valid_o  output  1  registered; equals OR of grants_o.
- grant_id_o  output  $clog2(NUM_PORTS)  registered index of the granted port. 0 when no grant.

Behaviour:
- Reset (asynchronous on reset_n_i low):
  - grants_o=0, grant_valid_o=0, grant_id_o=0.
  - State=IDLE, rotating pointer ptr=0, burst counter=0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
  - Release of reset is sampled on the next rising edge.
- States: IDLE, BUSY.
- Search rule:
  - Scan ports starting at index ptr, ascending with wrap modulo NUM_PORTS.
  - The first port with its request set wins.
- IDLE:
  - If requests_i is nonzero at edge t, load the winner into grants_o/grant_id_o and set grant_valid_o at edge t.
  - Grant is therefore visible the cycle after the request is first seen (1-cycle latency). Go to BUSY.
  - If requests_i is zero, stay in IDLE with outputs zero.
- BUSY, owner request still high: hold the grant unchanged. Requests from other ports are ignored.
- BUSY, owner request low at an edge (release):
  - Set ptr = (owner+1) mod NUM_PORTS.
  - Search the requests excluding the owner, starting at the new ptr.
  - If a winner exists, the grant moves directly to it at that same edge. There is no idle bubble and the state stays BUSY.
  - Otherwise clear the grant and go to IDLE.
- Update ptr only on release or forced rotation, never on a plain grant.
- Invariants:
  - grants_o is never multi-hot.
  - grants_o is never asserted for a port whose request was low at the granting edge.
  - A port dropping its request while not granted has no effect.
- Simultaneous release and new request from the same owner: the owner is excluded from that edge's search. It may win again only on a later search.
- Wrap-around: the owner at NUM_PORTS-1 releases → ptr=0.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- With the macro defined:
  - A burst counter resets to 1 when a new grant is issued and increments every BUSY cycle the grant is held.
  - When the counter reaches MAX_BURST and any other port is requesting, the next edge forces a rotation:
    - ptr = owner+1.
    - Search excluding the owner.
    - The grant moves to the winner.
    - The counter resets to 1.
  - If no other port is requesting, the owner keeps the grant and the counter saturates at MAX_BURST.
- Without the macro: no counter exists, and the owner holds the grant indefinitely while its request is high.

Test Plan:
- NUM_PORTS=4, MAX_BURST=4 for all scenarios.
- Reset: assert reset_n_i low mid-grant → grants_o=0000, grant_valid_o=0, grant_id_o=0 immediately; after release, requests 0101 → grant 0001 one edge later.
- Rotation: requests 1111 held; each owner drops its request for one cycle in turn → grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between handovers.
- Lock: grant on port 1, then requests 1110 held for 20 cycles → grants_o stays 0010 (macro off).
- Release to idle: only port 2 requests, then drops → grant 0100, then 0000 and grant_valid_o=0 on the edge after the drop; ptr=3, so a later request 1001 → grant 1000.
- Wrap: port 3 owns and releases while requests 0011 → grant 0001 (ptr wrapped to 0).
- Burst limit (ARB_BURST_LIMIT_EN): requests 0011 held → port 0 granted for exactly 4 cycles, then 0010 for 4 cycles, alternating. With only 0001 held, port 0 keeps the grant indefinitely.

Source files
------------

// File: rtl/rr_lock_arbiter_if.sv
// Requester-side handshake bundle for rr_lock_arbiter: request vector in,
// registered one-hot grant plus valid/index out.
interface rr_lock_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    localparam int IDW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] requests_i;
    logic [NUM_PORTS-1:0] grants_o;
    logic                 grant_valid_o;
    logic [IDW-1:0]       grant_id_o;

    // master drives requests (requester side), slave is the arbiter
    modport master (
        output requests_i,
        input  grants_o,
        input  grant_valid_o,
        input  grant_id_o
    );

    modport slave (
        input  requests_i,
        output grants_o,
        output grant_valid_o,
        output grant_id_o
    );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant lock: owner keeps the grant while requesting,
// pointer rotates past it on release. Optional burst cap via ARB_BURST_LIMIT_EN.
module rr_lock_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_BURST = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    rr_lock_arbiter_if.slave   arb
);
    localparam int IDW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || MAX_BURST < 1) begin : g_bad_params
        $error("rr_lock_arbiter: NUM_PORTS must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q,       state_d;
    logic [IDW-1:0]       ptr_q,         ptr_d;
    logic [NUM_PORTS-1:0] grants_q,      grants_d;
    logic [IDW-1:0]       grant_id_q,    grant_id_d;
    logic                 grant_valid_q, grant_valid_d;

`ifdef ARB_BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0]        burst_q,       burst_d;
`endif

    logic [NUM_PORTS-1:0] others_req;
    logic [IDW-1:0]       rot_ptr;
    logic [IDW:0]         hit_idle;
    logic [IDW:0]         hit_rot;
    logic                 rotate;

    // MSB of the result flags a hit; low bits hold the winning index
    function automatic logic [IDW:0] search(input logic [NUM_PORTS-1:0] req,
                                            input logic [IDW-1:0]       start);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = IDW'((int'(start) + i) % NUM_PORTS);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_PORTS - 1)) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grants_d      = grants_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
`ifdef ARB_BURST_LIMIT_EN
        burst_d       = burst_q;
`endif
        rotate        = 1'b0;
        others_req    = arb.requests_i & ~grants_q;
        rot_ptr       = inc_wrap(grant_id_q);
        hit_idle      = search(arb.requests_i, ptr_q);
        hit_rot       = search(others_req, rot_ptr);

        case (state_q)
            IDLE: begin
                if (hit_idle[IDW]) begin
                    grants_d      = onehot(hit_idle[IDW-1:0]);
                    grant_id_d    = hit_idle[IDW-1:0];
                    grant_valid_d = 1'b1;
                    state_d       = BUSY;
`ifdef ARB_BURST_LIMIT_EN
                    burst_d       = BW'(1);
`endif
                end else begin
                    grants_d      = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (!arb.requests_i[grant_id_q]) begin
                    rotate = 1'b1;
                end
`ifdef ARB_BURST_LIMIT_EN
                // at the cap the owner yields only if someone else is waiting
                else if (burst_q == BW'(MAX_BURST)) begin
                    rotate = |others_req;
                end else begin
                    burst_d = burst_q + 1'b1;
                end
`endif
                if (rotate) begin
                    ptr_d = rot_ptr;
                    if (hit_rot[IDW]) begin
                        grants_d      = onehot(hit_rot[IDW-1:0]);
                        grant_id_d    = hit_rot[IDW-1:0];
                        grant_valid_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
                        burst_d       = BW'(1);
`endif
                    end else begin
                        grants_d      = '0;
                        grant_id_d    = '0;
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
`ifdef ARB_BURST_LIMIT_EN
                        burst_d       = '0;
`endif
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                grants_d      = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grants_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
            burst_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grants_q      <= grants_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
`ifdef ARB_BURST_LIMIT_EN
            burst_q       <= burst_d;
`endif
        end
    end

    assign arb.grants_o      = grants_q;
    assign arb.grant_valid_o = grant_valid_q;
    assign arb.grant_id_o    = grant_id_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NUM_PORTS=4, MAX_BURST=4); the burst
// scenario follows ARB_BURST_LIMIT_EN when that macro is defined.
module tb_rr_lock_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   fails  = 0;

    rr_lock_arbiter_if #(.NUM_PORTS(N)) arb ();

    rr_lock_arbiter #(.NUM_PORTS(N), .MAX_BURST(MB)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .arb       (arb)
    );

    always #5 clk = ~clk;

    // packs {valid, id, grants} expected for a given one-hot grant vector
    function automatic logic [6:0] exp_word(input logic [3:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = 2'(i);
        end
        return {|g, id, g};
    endfunction

    function automatic logic [6:0] obs_word();
        return {arb.grant_valid_o, arb.grant_id_o, arb.grants_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        reset_n        = 1'b0;
        arb.requests_i = 4'b0000;
        repeat (2) tick();
        obs = obs_word();
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b required %b", obs, 7'b0);
        end
        @(negedge clk);
        reset_n        = 1'b1;
        arb.requests_i = 4'b0101;
        #1;
        obs = obs_word();
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_latency: got %b required %b", obs, 7'b0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = obs_word();
            checks++;
            if (obs !== exp_word(4'b0001)) begin
                fails++;
                $display("FAIL reset_first_grant[%0d]: got %b required %b", i, obs, exp_word(4'b0001));
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        obs = obs_word();
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_async_drop: got %b required %b", obs, 7'b0);
        end
        tick();
        obs = obs_word();
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_held: got %b required %b", obs, 7'b0);
        end
        arb.requests_i = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        obs = obs_word();
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got %b required %b", obs, 7'b0);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] rv [10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
        logic [3:0] ev [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
        logic [6:0] obs;
        for (int i = 0; i < 10; i++) begin
            arb.requests_i = rv[i];
            tick();
            obs = obs_word();
            checks++;
            if (obs !== exp_word(ev[i])) begin
                fails++;
                $display("FAIL rotation[%0d]: got %b required %b", i, obs, exp_word(ev[i]));
            end
        end
    endtask

    task automatic test_lock();
        logic [3:0] rv;
        logic [3:0] ev;
        logic [6:0] obs;
        for (int i = 0; i < 22; i++) begin
            rv = (i == 0) ? 4'b0010 : (i == 21) ? 4'b0000 : 4'b1110;
            ev = (i == 21) ? 4'b0000 : 4'b0010;
            arb.requests_i = rv;
            tick();
            obs = obs_word();
            checks++;
            if (obs !== exp_word(ev)) begin
                fails++;
                $display("FAIL lock[%0d]: got %b required %b", i, obs, exp_word(ev));
            end
        end
    endtask

    task automatic test_release_idle();
        logic [3:0] rv [5] = '{4'b0100, 4'b0000, 4'b1001, 4'b1000, 4'b0000};
        logic [3:0] ev [5] = '{4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        logic [6:0] obs;
        for (int i = 0; i < 5; i++) begin
            arb.requests_i = rv[i];
            tick();
            obs = obs_word();
            checks++;
            if (obs !== exp_word(ev[i])) begin
                fails++;
                $display("FAIL release_idle[%0d]: got %b required %b", i, obs, exp_word(ev[i]));
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] rv [4] = '{4'b1000, 4'b0011, 4'b0010, 4'b0000};
        logic [3:0] ev [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0000};
        logic [6:0] obs;
        for (int i = 0; i < 4; i++) begin
            arb.requests_i = rv[i];
            tick();
            obs = obs_word();
            checks++;
            if (obs !== exp_word(ev[i])) begin
                fails++;
                $display("FAIL wrap[%0d]: got %b required %b", i, obs, exp_word(ev[i]));
            end
        end
    endtask

    task automatic test_burst();
        logic [3:0] rv;
        logic [3:0] ev;
        logic [6:0] obs;
        for (int i = 0; i < 40; i++) begin
            rv = (i < 16) ? 4'b0011 : (i == 16 || i == 39) ? 4'b0000 : 4'b0001;
`ifdef ARB_BURST_LIMIT_EN
            ev = (i < 16) ? (((i / MB) % 2 == 0) ? 4'b0001 : 4'b0010) : rv;
`else
            ev = (i < 16) ? 4'b0001 : rv;
`endif
            arb.requests_i = rv;
            tick();
            obs = obs_word();
            checks++;
            if (obs !== exp_word(ev)) begin
                fails++;
                $display("FAIL burst[%0d]: got %b required %b", i, obs, exp_word(ev));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
`ifndef ARB_BURST_LIMIT_EN
        test_lock();
`endif
        test_release_idle();
        test_wrap();
        test_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
